adc_serial_chain_interface: RTL and testbench
=============================================

ADC_SERIAL_CHAIN_INTERFACE -- requirements
Module: adc_serial_chain_interface

Interface
REQ-001 SHALL have parameter DATA_W, default 16, bits per converter word.
REQ-002 SHALL have parameter N_CH, default 2, number of daisy-chained converters, >=1.
REQ-003 SHALL have parameter SCK_HALF, default 1, CLK cycles per SCK half-period, >=1.
REQ-004 SHALL have parameter CNV_CYCLES, default 46, CLK cycles CNV is held high for conversion, >=1.
REQ-005 CLK  input  1  single system clock, all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 CNV_START  input  1  one-cycle conversion request.
REQ-008 SDO  input  1  serial data from last converter in chain.
REQ-009 BUSY  output  1  high while a conversion or readout is in progress.
REQ-010 CNV  output  1  converter start and chip-select line.
REQ-011 SCK  output  1  serial clock, idles low.
REQ-012 SDI  output  1  chain input to first converter, constant 1.
REQ-013 RESULT  output  N_CH*DATA_W  packed words, channel c at bits [c*DATA_W +: DATA_W].
REQ-014 VALID  output  1  one-cycle pulse, RESULT updated.
REQ-015 OVERRUN  output  1  one-cycle pulse, CNV_START rejected.

Function
REQ-016 SHALL implement states IDLE, CONVERT, READ, DONE; BUSY = (state != IDLE).
REQ-017 IDLE: CNV=0, SCK=0; CNV_START=1 sampled at edge n -> CONVERT, CNV=1 from edge n.
REQ-018 CONVERT: CNV high exactly CNV_CYCLES cycles; at edge n+CNV_CYCLES -> READ, CNV=0, SCK=0.
REQ-019 READ: B = N_CH*DATA_W SCK periods; SCK rises at n+CNV_CYCLES+SCK_HALF*(2k+1) and falls at n+CNV_CYCLES+SCK_HALF*(2k+2), k=0..B-1.
REQ-020 SDO SHALL be sampled on the same CLK edge that drives SCK high, one bit per period.
REQ-021 Bit order: first received word = channel 0; each word MSB first.
REQ-022 Shift register SHALL be internal; RESULT SHALL not change during READ.
REQ-023 On final SCK falling edge -> DONE; in DONE: RESULT loaded, VALID=1 for one cycle, BUSY=1.
REQ-024 DONE -> IDLE next edge unconditionally; total latency CNV_START to VALID = CNV_CYCLES+2*SCK_HALF*B cycles.
REQ-025 CNV_START while BUSY=1 (incl. DONE) SHALL be ignored and pulse OVERRUN next cycle; operation unaffected.
REQ-026 CNV_START in IDLE SHALL never raise OVERRUN.
REQ-027 RESULT SHALL hold last value between VALID pulses.
REQ-028 Bit and cycle counters SHALL be sized for B and max(CNV_CYCLES, SCK_HALF) without wrap.
REQ-029 SDI SHALL be 1 at all times, including reset.

Reset
REQ-030 rst=1 SHALL at next edge force IDLE, CNV=0, SCK=0, BUSY=0, VALID=0, OVERRUN=0, RESULT=0, counters and shift register 0.
REQ-031 rst SHALL take priority over CNV_START; reset during CONVERT or READ SHALL abort with no VALID.
REQ-032 First CNV_START after rst release SHALL be accepted normally.

Verification (DATA_W=16, N_CH=2, SCK_HALF=1, CNV_CYCLES=46 unless noted)
REQ-033 Basic: CNV_START at edge n, SDO model shifts 0xA5C3 then 0x1234 -> CNV high n..n+45, 32 SCK pulses, VALID at n+110, RESULT=0x1234_A5C3, BUSY low at n+111.
REQ-034 Overrun: second CNV_START at n+20 and at n+110 -> OVERRUN pulses at n+21 and n+111, single VALID at n+110, RESULT unchanged.
REQ-035 Reset mid-READ: rst at n+70 -> next edge CNV=0, SCK=0, BUSY=0, RESULT=0, no VALID; new CNV_START converts normally.
REQ-036 Slow SCK: SCK_HALF=3, N_CH=1, SDO all ones -> SCK period 6 cycles, VALID at n+46+96, RESULT=0xFFFF.
REQ-037 Back-to-back: CNV_START at n+111 (first IDLE cycle) -> accepted, no OVERRUN, second VALID at n+221.
REQ-038 Idle: no CNV_START for 1000 cycles -> SCK, CNV, VALID, OVERRUN stay 0, SDI stays 1.

Source files
------------

// File: rtl/adc_serial_chain_interface.sv
// Daisy-chained SAR ADC readout controller.
// A conversion request raises CNV for CNV_CYCLES cycles, then N_CH*DATA_W
// SCK periods clock the chain out of SDO. The packed words are published
// on RESULT together with a one-cycle VALID pulse. Requests that arrive
// while busy are dropped and flagged with OVERRUN on the following cycle.
//
// Request handshake: CNV_START is a single-cycle strobe. It is accepted in
// any cycle where BUSY is low and rst is low. Acceptance is visible in the
// same cycle because CNV rises combinationally. A strobe seen while BUSY is
// high is dropped, and OVERRUN pulses for exactly one cycle afterwards.
// There is no back-pressure: the requester can watch BUSY but is never
// stalled.
module adc_serial_chain_interface #(
    parameter int DATA_W     = 16,
    parameter int N_CH       = 2,
    parameter int SCK_HALF   = 1,
    parameter int CNV_CYCLES = 46
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic                     CNV_START,
    input  logic                     SDO,
    output logic                     BUSY,
    output logic                     CNV,
    output logic                     SCK,
    output logic                     SDI,
    output logic [N_CH*DATA_W-1:0]   RESULT,
    output logic                     VALID,
    output logic                     OVERRUN
);

    localparam int B       = N_CH * DATA_W;
    localparam int CYC_MAX = (CNV_CYCLES > SCK_HALF) ? CNV_CYCLES : SCK_HALF;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);
    localparam int BIT_W   = $clog2(B + 1);

    localparam logic [CYC_W-1:0] CNV_LAST  = CYC_W'(CNV_CYCLES - 1);
    localparam logic [CYC_W-1:0] HALF_LAST = CYC_W'(SCK_HALF - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(B - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_READ    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CYC_W-1:0] cyc_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic             sck_q;
    logic             overrun_q;
    logic [B-1:0]     shift_q;
    logic [B-1:0]     shift_mapped;
    logic [B-1:0]     result_q;
    logic             half_tick;

    // The request cycle itself is the first CNV cycle, so the CONVERT state
    // covers the remaining CNV_CYCLES-1 cycles.
    assign CNV     = (state_q == S_CONVERT) ||
                     ((state_q == S_IDLE) && CNV_START && !rst);
    assign BUSY    = (state_q != S_IDLE);
    assign VALID   = (state_q == S_DONE);
    assign SCK     = sck_q;
    assign SDI     = 1'b1;
    assign RESULT  = result_q;
    assign OVERRUN = overrun_q;

    assign half_tick = (cyc_cnt == HALF_LAST);

    // The first word shifted in belongs to channel 0 and ends up in the top
    // of the shift register; reverse the word order for RESULT.
    always_comb begin
        shift_mapped = '0;
        for (int c = 0; c < N_CH; c++) begin
            shift_mapped[c*DATA_W +: DATA_W] = shift_q[(N_CH-1-c)*DATA_W +: DATA_W];
        end
    end

    // Next-state logic for the conversion/readout sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (CNV_START) begin
                    state_d = (CNV_CYCLES == 1) ? S_READ : S_CONVERT;
                end
            end
            S_CONVERT: begin
                if (cyc_cnt == CNV_LAST) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (half_tick && sck_q && (bit_cnt == BIT_LAST)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register, timing counters, SCK generation and data capture.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cyc_cnt   <= '0;
            bit_cnt   <= '0;
            sck_q     <= 1'b0;
            overrun_q <= 1'b0;
            shift_q   <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            overrun_q <= CNV_START && (state_q != S_IDLE);
            case (state_q)
                S_IDLE: begin
                    if (CNV_START) begin
                        cyc_cnt <= (CNV_CYCLES == 1) ? '0 : CYC_W'(1);
                        bit_cnt <= '0;
                        sck_q   <= 1'b0;
                    end
                end
                S_CONVERT: begin
                    if (cyc_cnt == CNV_LAST) begin
                        cyc_cnt <= '0;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                S_READ: begin
                    if (half_tick) begin
                        cyc_cnt <= '0;
                        sck_q   <= !sck_q;
                        if (!sck_q) begin
                            // Rising SCK edge: capture the bit the chain is presenting.
                            shift_q <= (shift_q << 1) | B'(SDO);
                        end else if (bit_cnt == BIT_LAST) begin
                            result_q <= shift_mapped;
                            bit_cnt  <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    cyc_cnt <= '0;
                end
                default: begin
                    cyc_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_serial_chain_interface.sv
// Bench for adc_serial_chain_interface: a default instance (2 x 16 bit,
// SCK_HALF=1) and a slow instance (1 x 16 bit, SCK_HALF=3) run side by side.
// Each cycle the expected outputs come from a timeline model: given the
// cycle a request was accepted, CNV/BUSY/SCK/VALID windows and the SDO bit
// stream follow from the documented timing formulas.
module tb_adc_serial_chain_interface;

  localparam int C  = 46;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cnv_start0, sdo0, busy0, cnv0, sck0, sdi0, valid0, overrun0;
  logic [31:0] result0;
  logic        cnv_start1, sdo1, busy1, cnv1, sck1, sdi1, valid1, overrun1;
  logic [15:0] result1;

  adc_serial_chain_interface dut (
    .CLK(clk), .rst(rst), .CNV_START(cnv_start0), .SDO(sdo0),
    .BUSY(busy0), .CNV(cnv0), .SCK(sck0), .SDI(sdi0),
    .RESULT(result0), .VALID(valid0), .OVERRUN(overrun0)
  );

  adc_serial_chain_interface #(
    .DATA_W(16), .N_CH(1), .SCK_HALF(3), .CNV_CYCLES(46)
  ) dut_slow (
    .CLK(clk), .rst(rst), .CNV_START(cnv_start1), .SDO(sdo1),
    .BUSY(busy1), .CNV(cnv1), .SCK(sck1), .SDI(sdi1),
    .RESULT(result1), .VALID(valid1), .OVERRUN(overrun1)
  );

  int checks = 0;
  int errors = 0;
  int t = 0;

  // timeline model state, one slot per instance
  bit          act[2];
  int          accn[2];
  logic [31:0] words[2];
  logic [31:0] next_w[2];
  logic [31:0] exp_res[2];
  bit          prev_req[2];
  bit          prev_busy[2];
  bit          prev_rst;

  // pulse/edge tallies
  int v_cnt[2];
  int o_cnt[2];
  int s_cnt[2];
  int c_cnt[2];

  always @(negedge clk) begin
    #2;
    if (valid0)   v_cnt[0]++;
    if (valid1)   v_cnt[1]++;
    if (overrun0) o_cnt[0]++;
    if (overrun1) o_cnt[1]++;
    if (sck0)     s_cnt[0]++;
    if (sck1)     s_cnt[1]++;
    if (cnv0)     c_cnt[0]++;
    if (cnv1)     c_cnt[1]++;
  end

  function automatic int half_of(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic int bits_of(int d);
    return (d == 0) ? 32 : 16;
  endfunction

  function automatic logic [31:0] rand_word(int d);
    logic [31:0] w;
    w = $urandom;
    if (d != 0) w[31:16] = 16'h0;
    return w;
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d t=%0d observed=%h expected=%h", tag, d, t, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, check all outputs.
  task automatic cyc(input bit r0, input bit r1, input bit rs);
    bit req[2];
    bit busy_m[2], cnv_m[2], valid_m[2], sck_m[2], ovr_m[2], sdo_m[2];
    req[0] = r0;
    req[1] = r1;
    rst = rs;
    cnv_start0 = r0;
    cnv_start1 = r1;
    for (int d = 0; d < 2; d++) begin
      int h, b, l, r, rp, k;
      h = half_of(d);
      b = bits_of(d);
      l = C + 2 * h * b;
      if (prev_rst) begin
        act[d] = 1'b0;
        exp_res[d] = 32'h0;
      end
      busy_m[d] = act[d] && (t >= accn[d] + 1) && (t <= accn[d] + l);
      ovr_m[d] = prev_req[d] && prev_busy[d] && !prev_rst;
      if (req[d] && !rs && !busy_m[d]) begin
        act[d] = 1'b1;
        accn[d] = t;
        words[d] = next_w[d];
        next_w[d] = rand_word(d);
      end
      cnv_m[d] = act[d] && (t >= accn[d]) && (t <= accn[d] + C - 1);
      valid_m[d] = act[d] && (t == accn[d] + l);
      r = t - (accn[d] + C);
      sck_m[d] = act[d] && (r >= 0) && (r < 2 * h * b) && (((r / h) % 2) == 1);
      rp = r + 1;
      if (act[d] && (rp >= 0) && (rp < 2 * h * b)) begin
        k = rp / (2 * h);
        sdo_m[d] = words[d][(k / DW) * DW + (DW - 1 - (k % DW))];
      end else begin
        sdo_m[d] = 1'($urandom_range(0, 1));
      end
      if (valid_m[d]) exp_res[d] = words[d];
      prev_req[d] = req[d];
      prev_busy[d] = busy_m[d];
    end
    prev_rst = rs;
    sdo0 = sdo_m[0];
    sdo1 = sdo_m[1];
    #1;
    chk("cnv",     0, 32'(cnv0),     32'(cnv_m[0]));
    chk("busy",    0, 32'(busy0),    32'(busy_m[0]));
    chk("sck",     0, 32'(sck0),     32'(sck_m[0]));
    chk("valid",   0, 32'(valid0),   32'(valid_m[0]));
    chk("overrun", 0, 32'(overrun0), 32'(ovr_m[0]));
    chk("sdi",     0, 32'(sdi0),     32'h1);
    chk("result",  0, result0,       exp_res[0]);
    chk("cnv",     1, 32'(cnv1),     32'(cnv_m[1]));
    chk("busy",    1, 32'(busy1),    32'(busy_m[1]));
    chk("sck",     1, 32'(sck1),     32'(sck_m[1]));
    chk("valid",   1, 32'(valid1),   32'(valid_m[1]));
    chk("overrun", 1, 32'(overrun1), 32'(ovr_m[1]));
    chk("sdi",     1, 32'(sdi1),     32'h1);
    chk("result",  1, 32'(result1),  exp_res[1]);
    @(posedge clk);
    @(negedge clk);
    t++;
  endtask

  initial begin
    int n;
    int v0, v1, o0, o1, s0, s1, c0, c1;
    rst = 1'b1;
    cnv_start0 = 1'b0;
    cnv_start1 = 1'b0;
    sdo0 = 1'b0;
    sdo1 = 1'b0;
    prev_rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      act[d] = 1'b0;
      accn[d] = 0;
      words[d] = 32'h0;
      exp_res[d] = 32'h0;
      prev_req[d] = 1'b0;
      prev_busy[d] = 1'b0;
      v_cnt[d] = 0;
      o_cnt[d] = 0;
      s_cnt[d] = 0;
      c_cnt[d] = 0;
      next_w[d] = rand_word(d);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);

    // reset state, then release with a few quiet cycles
    cyc(1'b0, 1'b0, 1'b1);
    repeat (4) cyc(1'b0, 1'b0, 1'b0);

    // basic readout, overrun in CONVERT and DONE, back-to-back, slow SCK
    next_w[0] = 32'h1234_A5C3;
    next_w[1] = 32'h0000_FFFF;
    n = t;
    v0 = v_cnt[0]; v1 = v_cnt[1]; o0 = o_cnt[0]; o1 = o_cnt[1];
    while (t < n + 240) begin
      cyc((t == n) || (t == n + 20) || (t == n + 110) || (t == n + 111), t == n, 1'b0);
    end
    chk("valid_pulses_basic",   0, 32'(v_cnt[0] - v0), 32'd2);
    chk("valid_pulses_slow",    1, 32'(v_cnt[1] - v1), 32'd1);
    chk("overrun_pulses_basic", 0, 32'(o_cnt[0] - o0), 32'd2);
    chk("overrun_pulses_slow",  1, 32'(o_cnt[1] - o1), 32'd0);

    // reset in the middle of READ aborts, next request converts normally
    n = t;
    v0 = v_cnt[0]; v1 = v_cnt[1];
    while (t < n + 70) cyc(t == n, t == n, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    while (t < n + 75) cyc(1'b0, 1'b0, 1'b0);
    chk("aborted_no_valid", 0, 32'(v_cnt[0] - v0), 32'd0);
    chk("aborted_no_valid", 1, 32'(v_cnt[1] - v1), 32'd0);
    n = t;
    while (t < n + 150) cyc(t == n, t == n, 1'b0);
    chk("after_reset_valid", 0, 32'(v_cnt[0] - v0), 32'd1);
    chk("after_reset_valid", 1, 32'(v_cnt[1] - v1), 32'd1);

    // random requests with occasional resets
    repeat (800) begin
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0, $urandom_range(0, 399) == 0);
    end

    // long idle stretch: drain, then nothing may toggle
    repeat (200) cyc(1'b0, 1'b0, 1'b0);
    v0 = v_cnt[0]; v1 = v_cnt[1]; o0 = o_cnt[0]; o1 = o_cnt[1];
    s0 = s_cnt[0]; s1 = s_cnt[1]; c0 = c_cnt[0]; c1 = c_cnt[1];
    repeat (1000) cyc(1'b0, 1'b0, 1'b0);
    chk("idle_valid",   0, 32'(v_cnt[0] - v0), 32'd0);
    chk("idle_valid",   1, 32'(v_cnt[1] - v1), 32'd0);
    chk("idle_overrun", 0, 32'(o_cnt[0] - o0), 32'd0);
    chk("idle_overrun", 1, 32'(o_cnt[1] - o1), 32'd0);
    chk("idle_sck",     0, 32'(s_cnt[0] - s0), 32'd0);
    chk("idle_sck",     1, 32'(s_cnt[1] - s1), 32'd0);
    chk("idle_cnv",     0, 32'(c_cnt[0] - c0), 32'd0);
    chk("idle_cnv",     1, 32'(c_cnt[1] - c1), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
